// File: rtl/sync_fifo_param_pkg.sv
// Shared types, default sizing and elaboration helpers for the single-clock FIFO family.
// Flags travel as one packed struct so the top registers them in a single step.
package sync_fifo_param_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RESET = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

  // Depth must be a power of two so the pointers can wrap without compare logic.
  function automatic bit thresh_ok(input int depth, input int afull, input int aempty);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (aempty < afull) && (afull <= depth);
  endfunction

  function automatic fifo_flags_t flags_from_count(input int cnt, input int depth,
                                                   input int afull, input int aempty);
    fifo_flags_t f;
    f.full         = (cnt == depth);
    f.empty        = (cnt == 0);
    f.almost_full  = (cnt >= afull);
    f.almost_empty = (cnt <= aempty);
    return f;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array: registered write port, combinational read port, contents never reset.
// Zero read latency; no flow control of its own, the caller gates wr_en.
module fifo_ram
  import sync_fifo_param_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags and sticky errors.
// Standard mode: 1-cycle read latency; FWFT: head shown combinationally. Writes to full / reads from empty are dropped and flagged.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter  int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter  int DEPTH         = DEF_DEPTH,
  parameter  int AFULL_THRESH  = DEPTH - 2,
  parameter  int AEMPTY_THRESH = 2,
  parameter  int FWFT          = 0,
  localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  generate
    if (!thresh_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_param
      $error("sync_fifo_param: need power-of-two DEPTH>=4 and AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end
  endgenerate

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  fifo_flags_t           flags_q;
  fifo_flags_t           flags_next;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses the registered flags, so a read on a full FIFO frees no room
  // for a write in the same cycle (and vice versa on empty).
  assign wr_acc = wr_en & ~flags_q.full;
  assign rd_acc = rd_en & ~flags_q.empty;

  always_comb begin
    count_next = count + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
  end

  assign flags_next = flags_from_count(int'(count_next), DEPTH, AFULL_THRESH, AEMPTY_THRESH);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      flags_q   <= FLAGS_RESET;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      count   <= count_next;
      flags_q <= flags_next;
      // A new error in the same cycle as clr_err must not be lost.
      if (wr_en & flags_q.full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en & flags_q.empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Masked while empty so stale RAM contents never appear on the bus.
      assign rd_data  = flags_q.empty ? '0 : ram_rd_data;
      assign rd_valid = ~flags_q.empty;
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) begin
            rd_data <= ram_rd_data;
          end
        end
      end
    end
  endgenerate

endmodule
